sram_ctrl: RTL
==============

Name: sram_ctrl

Overview:
- Initiator-side controller for the single-port synchronous SRAM used by the CPU.
- Accepts load/store requests from the CPU datapath over a valid/ready channel and drives the SRAM address, write-data and write-enable pins.
- Reads are single-word or burst. The fixed 1-cycle SRAM read latency is tracked internally, and returned words are buffered so the consumer can apply backpressure without losing data.

Parameters:
- ADDR_WIDTH, 12, SRAM address width; addresses wrap modulo 2^ADDR_WIDTH.
- WORD_WIDTH, 16, SRAM word width.
- LEN_WIDTH, 4, burst length field width; a read transfers req_len+1 words (1..16).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1=write single word, 0=read burst
- req_addr  in  ADDR_WIDTH  start address
- req_wdata  in  WORD_WIDTH  write data (writes only)
- req_len  in  LEN_WIDTH  read words minus one; ignored for writes
- rsp_valid  out  1  rsp_data valid
- rsp_ready  in  1  consumer takes the word
- rsp_data  out  WORD_WIDTH  read word
- rsp_last  out  1  final word of the burst (qualified by rsp_valid)
- busy  out  1  high in any state other than IDLE
- mem_addr  out  ADDR_WIDTH  to SRAM i_addr, registered
- mem_wdata  out  WORD_WIDTH  to SRAM i_data, registered
- mem_we  out  1  to SRAM i_we, registered
- mem_rdata  in  WORD_WIDTH  from SRAM o_data

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All outputs are 0 after the edge: req_ready, rsp_valid, rsp_last, busy, mem_we, mem_addr, mem_wdata, rsp_data.
  - FSM goes to IDLE, the response FIFO is flushed, the in-flight tracker is cleared and the burst counter is cleared.
- Reset mid-burst aborts the burst. No rsp_valid appears in the cycle after the reset edge, and no stale word appears later.
- After reset deasserts, req_ready=1 in IDLE.
- The SRAM model: at each edge with i_we=0, o_data updates to mem[i_addr]. Data for an address presented at edge N is sampled by the controller at edge N+1.
- FSM states: IDLE, WRITE, READ, DRAIN. req_ready=1 only in IDLE; requests in other states are not accepted and have no effect.
- IDLE, on req_valid&req_ready at edge E0:
  - Write: mem_addr<=req_addr, mem_wdata<=req_wdata, mem_we<=1, go to WRITE.
  - Read: mem_addr<=req_addr, mem_we<=0, remaining<=req_len, in-flight +1, go to READ (or DRAIN if req_len=0).
- WRITE: lasts exactly one cycle, so mem_we is high for exactly one cycle. At E1: mem_we<=0, go to IDLE. Sustained write rate is one write every 2 cycles. Writes produce no response.
- READ: issue the next address (mem_addr<=mem_addr+1, wrapping) when (fifo_count + inflight - pop) < 3, where pop = rsp_valid&rsp_ready this cycle.
  - Each issue decrements remaining. When the last address has been issued, go to DRAIN.
  - mem_we stays 0 throughout.
- In-flight tracking: a 2-stage valid shift register tracks issued addresses. Stage 2 writes mem_rdata into the FIFO, tagging the word with last=1 when it is the burst's final word.
- Response FIFO: depth 3. Head drives rsp_data/rsp_last; rsp_valid = FIFO non-empty. Pop on rsp_valid&rsp_ready. Push and pop in the same cycle are allowed. The credit rule guarantees the FIFO never overflows; overflow is a design error (assertion).
- DRAIN: mem_addr and mem_we are held; the SRAM re-reads the same address, which is harmless. When inflight=0, the FIFO is empty and no push is pending, go to IDLE. req_ready=1 in the following cycle.
- Latency: with rsp_ready held at 1, the first rsp_valid is asserted 2 cycles after the accept edge. Throughput is then 1 word/cycle.
- rsp_data and rsp_last must stay stable while rsp_valid=1 and rsp_ready=0.
- Address arithmetic is ADDR_WIDTH-bit unsigned and wraps 2^ADDR_WIDTH-1 -> 0.

Test Plan:
- Write then read: write 0x12 <- 0xBEEF; then read 0x12 len=0. mem_we high for exactly 1 cycle. rsp_valid appears 2 cycles after the read accept with rsp_data=0xBEEF and rsp_last=1. req_ready returns after the pop.
- Burst, no backpressure: preload 0x40..0x43 = 0xA0..0xA3; read 0x40 len=3 with rsp_ready=1. mem_addr sequence is 0x40,41,42,43 on consecutive cycles. rsp_valid is high for 4 consecutive cycles carrying 0xA0..0xA3, with rsp_last only on 0xA3.
- Backpressure: same burst with rsp_ready=0 for 4 cycles after the first word appears. mem_addr stops advancing once fifo_count+inflight=3. rsp_data holds 0xA0. When rsp_ready rises, all 4 words arrive in order with no loss or duplication.
- Wrap: read 0xFFE len=3. Issued addresses are 0xFFE,0xFFF,0x000,0x001 and data returns in that order.
- Reset mid-burst: pulse rst_n=0 during the 3rd cycle of a len=15 burst. After the edge, all outputs are 0. No rsp_valid follows. A new read of a single word afterwards returns correct data.
- Busy rejection: assert req_valid continuously during a len=7 burst. req_ready=0 and no new mem_addr is issued until DRAIN completes. The pending request is accepted on the first IDLE cycle.

Source files
------------

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: CPU-side request/response channel of the SRAM controller.
//   req_*  : load/store request (valid/ready), driven by the CPU datapath
//   rsp_*  : read-data return (valid/ready), consumed by the CPU datapath
// Modports: master = CPU datapath, slave = sram_ctrl.
interface sram_ctrl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 16,
  parameter int LEN_WIDTH  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WORD_WIDTH-1:0] req_wdata;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WORD_WIDTH-1:0] rsp_data;
  logic                  rsp_last;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: initiator-side controller for a single-port synchronous SRAM
// with a fixed 1-cycle read latency.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : request/response channel (sram_ctrl_if.slave)
//   busy       : high whenever the FSM is not in IDLE
//   mem_addr, mem_wdata, mem_we : registered SRAM pins
//   mem_rdata  : SRAM read data
// Reads return through a 3-deep FIFO; address issue is credit-limited so that
// words already in the FIFO plus words still in flight never exceed 3.
module sram_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 16,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_ctrl_if.slave            bus,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [WORD_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                state_r;
  logic                  req_ready_r;
  logic                  busy_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [WORD_WIDTH-1:0] mem_wdata_r;
  logic                  mem_we_r;
  logic [LEN_WIDTH-1:0]  remaining_r;
  // s1: address on the SRAM pins; s2: SRAM has latched it, data arrives next edge
  logic                  s1_r, s1_last_r, s2_r, s2_last_r;
  logic [WORD_WIDTH-1:0] fifo_data_r [0:2];
  logic                  fifo_last_r [0:2];
  logic [1:0]            wr_ptr_r, rd_ptr_r, count_r;

  logic                  accept_s, push_s, pop_s, issue_s;
  logic [2:0]            occupancy_s;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    if (p == 2'd2) return 2'd0;
    else           return p + 2'd1;
  endfunction

  assign accept_s    = bus.req_valid & req_ready_r;
  assign push_s      = s2_r;
  assign pop_s       = (count_r != 2'd0) & bus.rsp_ready;
  // a pop this cycle frees a slot in time for the word issued now
  assign occupancy_s = {1'b0, count_r} + {2'b00, s1_r} + {2'b00, s2_r} - {2'b00, pop_s};
  assign issue_s     = (state_r == READ) && (occupancy_s < 3'd3);

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = (count_r != 2'd0);
  assign bus.rsp_data  = fifo_data_r[rd_ptr_r];
  assign bus.rsp_last  = fifo_last_r[rd_ptr_r];
  assign busy          = busy_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wdata     = mem_wdata_r;
  assign mem_we        = mem_we_r;

  // Control FSM, SRAM pin registers and in-flight tracker
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_we_r    <= 1'b0;
      remaining_r <= '0;
      s1_r        <= 1'b0;
      s1_last_r   <= 1'b0;
      s2_r        <= 1'b0;
      s2_last_r   <= 1'b0;
    end else begin
      s2_r      <= s1_r;
      s2_last_r <= s1_last_r;
      s1_r      <= 1'b0;
      s1_last_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mem_addr_r  <= bus.req_addr;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (bus.req_we) begin
              mem_wdata_r <= bus.req_wdata;
              mem_we_r    <= 1'b1;
              state_r     <= WRITE;
            end else begin
              mem_we_r    <= 1'b0;
              remaining_r <= bus.req_len;
              s1_r        <= 1'b1;
              s1_last_r   <= (bus.req_len == '0);
              state_r     <= (bus.req_len == '0) ? DRAIN : READ;
            end
          end else begin
            // also raises req_ready on the first edge after reset
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        WRITE: begin
          mem_we_r    <= 1'b0;
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
        READ: begin
          if (issue_s) begin
            mem_addr_r  <= mem_addr_r + ADDR_WIDTH'(1);
            remaining_r <= remaining_r - LEN_WIDTH'(1);
            s1_r        <= 1'b1;
            s1_last_r   <= (remaining_r == LEN_WIDTH'(1));
            if (remaining_r == LEN_WIDTH'(1)) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // s2 covers the push pending at this edge
          if (!s1_r && !s2_r && (count_r == 2'd0)) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b0;
          busy_r      <= 1'b0;
          mem_we_r    <= 1'b0;
        end
      endcase
    end
  end

  // Response FIFO: push from tracker stage 2, pop on rsp handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        fifo_data_r[i] <= '0;
        fifo_last_r[i] <= 1'b0;
      end
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= mem_rdata;
        fifo_last_r[wr_ptr_r] <= s2_last_r;
        wr_ptr_r              <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  sram_ctrl_chk #(.WORD_WIDTH(WORD_WIDTH)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .count     (count_r),
    .rsp_valid (bus.rsp_valid),
    .rsp_ready (bus.rsp_ready),
    .rsp_data  (bus.rsp_data),
    .rsp_last  (bus.rsp_last)
  );

endmodule

// sram_ctrl_chk: protocol checks for sram_ctrl (FIFO overflow, response hold
// under backpressure). Contains only assertions.
module sram_ctrl_chk #(
  parameter int WORD_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  push,
  input logic                  pop,
  input logic [1:0]            count,
  input logic                  rsp_valid,
  input logic                  rsp_ready,
  input logic [WORD_WIDTH-1:0] rsp_data,
  input logic                  rsp_last
);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == 2'd3)));

  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_last)));
endmodule
